// File: rtl/cfg_shift_pkg.sv
// Shared types and defaults for the configuration shift-chain transmitter.
package cfg_shift_pkg;

  localparam int CFG_WIDTH_DEFAULT = 12;
  localparam int CFG_DIV_DEFAULT   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    DONE  = 2'd3
  } cfg_tx_state_t;

endpackage

// File: rtl/cfg_shift_tx_sync_2ff.sv
// Two-flop synchronizer bringing the chain's echo pin into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cfg_shift_tx.sv
// Serial loader for the oscillator-bank configuration chain: shifts a word out
// MSB-first on a divided shift_clk and captures the chain's previous contents.
module cfg_shift_tx
  import cfg_shift_pkg::*;
#(
  parameter int WIDTH = CFG_WIDTH_DEFAULT,
  parameter int DIV   = CFG_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             shift_clk,
  output logic             shift_dta,
  input  logic             shift_echo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_FIRST  = IW'(WIDTH - 1);

  cfg_tx_state_t    state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             cfg_ready_q;
  logic             shift_clk_q;
  logic             shift_dta_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             echo_s;
  logic             phase_last;

  sync_2ff u_echo_sync (
    .clk (clk),
    .rst (rst),
    .d_i (shift_echo),
    .q_o (echo_s)
  );

  assign phase_last = (phase_q == PHASE_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          state_d = SETUP;
          phase_d = '0;
          tx_d    = cfg_data;
          idx_d   = IDX_FIRST;
        end
      end
      SETUP: begin
        if (phase_last) begin
          // Echo is sampled just before the rise that would overwrite it.
          state_d = HIGH;
          phase_d = '0;
          rx_d    = {rx_q[WIDTH-2:0], echo_s};
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      HIGH: begin
        if (phase_last) begin
          phase_d = '0;
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            idx_d   = idx_q - 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      idx_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cfg_ready_q <= 1'b1;
      shift_clk_q <= 1'b0;
      shift_dta_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cfg_ready_q <= (state_d == IDLE);
      shift_clk_q <= (state_d == HIGH);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      if (state_d == SETUP) begin
        shift_dta_q <= tx_d[idx_d];
      end
      if (state_d == DONE) begin
        rd_data_q <= rx_q;
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign shift_clk = shift_clk_q;
  assign shift_dta = shift_dta_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;

endmodule
